// File: rtl/snake_step_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : snake_step_engine
//  Purpose  : Snake game-step engine. Keeps the body as a circular coordinate
//             buffer, advances the head once per speed tick, inspects the
//             destination map cell through a one-cycle-latency read port,
//             writes head/tail updates back to the map and requests new fruit.
//  Ports    : clk, reset (async, active-high), start, cobra_dir
//             map read  : update_renable, update_rx/ry, update_rdata
//             map write : update_wenable, update_wx/wy, update_wdata
//             fruit     : fruta_req, fruta_valid, fruta_wx/wy
//             status    : score, length, game_over, busy
//  Options  : SNAKE_WALL_WRAP_EN - head wraps around the map edges instead of
//             ending the game.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_step_engine #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int COORD_W     = 10,
    parameter int MAX_LEN     = 128,
    parameter int START_X     = 10,
    parameter int START_Y     = 10,
    parameter int TICK_INIT   = 50000000,
    parameter int TICK_MIN    = 5000000,
    parameter int TICK_STEP   = 2500000,
    parameter int SCORE_W     = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 cobra_dir,
    output logic                       update_renable,
    output logic [COORD_W-1:0]         update_rx,
    output logic [COORD_W-1:0]         update_ry,
    input  logic [1:0]                 update_rdata,
    output logic                       update_wenable,
    output logic [COORD_W-1:0]         update_wx,
    output logic [COORD_W-1:0]         update_wy,
    output logic [1:0]                 update_wdata,
    output logic                       fruta_req,
    input  logic                       fruta_valid,
    input  logic [COORD_W-1:0]         fruta_wx,
    input  logic [COORD_W-1:0]         fruta_wy,
    output logic [SCORE_W-1:0]         score,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       game_over,
    output logic                       busy
);

    localparam int c_PTR_W = $clog2(MAX_LEN);
    localparam int c_LEN_W = c_PTR_W + 1;

    localparam logic [1:0] c_EMPTY = 2'b00;
    localparam logic [1:0] c_BODY  = 2'b01;
    localparam logic [1:0] c_FRUIT = 2'b10;

    localparam logic [COORD_W-1:0] c_ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] c_X_MAX   = COORD_W'(MAPA_WIDTH - 1);
    localparam logic [COORD_W-1:0] c_Y_MAX   = COORD_W'(MAPA_HEIGHT - 1);
    localparam logic [COORD_W-1:0] c_START_X = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] c_START_Y = COORD_W'(START_Y);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(MAX_LEN);
    localparam logic [31:0]        c_T_INIT  = 32'(TICK_INIT);
    localparam logic [31:0]        c_T_MIN   = 32'(TICK_MIN);
    localparam logic [31:0]        c_T_STEP  = 32'(TICK_STEP);

    typedef enum logic [3:0] {
        S_WAIT_START = 4'd0,
        S_CLEAR      = 4'd1,
        S_FRUIT_REQ  = 4'd2,
        S_FRUIT_WR   = 4'd3,
        S_TICK       = 4'd4,
        S_MOVE       = 4'd5,
        S_CHECK      = 4'd6,
        S_ERASE      = 4'd7,
        S_OVER       = 4'd8
    } state_t;

    state_t                 r_state, w_next_state;
    logic [COORD_W-1:0]     r_cx, r_cy;          // CLEAR scan position
    logic [COORD_W-1:0]     r_nx, r_ny;          // head destination of this step
    logic [COORD_W-1:0]     r_fx, r_fy;          // fruit cell awaiting its write
    logic [COORD_W-1:0]     r_ex, r_ey;          // tail cell awaiting erase
    logic [31:0]            r_tick_cnt, r_period;
    logic [1:0]             r_dir;
    logic [c_PTR_W-1:0]     r_head;
    logic [c_LEN_W-1:0]     r_len;
    logic [SCORE_W-1:0]     r_score;
    logic                   r_game_over, r_erase_en, r_after_fruit;
    logic [COORD_W-1:0]     r_body_x [0:MAX_LEN-1];
    logic [COORD_W-1:0]     r_body_y [0:MAX_LEN-1];

    logic [1:0]             w_dir_eff;
    logic [c_PTR_W-1:0]     w_tail_ptr;
    logic [COORD_W-1:0]     w_hx, w_hy, w_tx, w_ty, w_nx, w_ny;
    logic                   w_off, w_clear_last, w_tick_done, w_start_ok;
    logic                   w_hit_tail, w_grow, w_accept, w_len_full;

    // A reversal onto the neck is ignored; a lone head may turn freely.
    assign w_dir_eff = ((r_len > c_LEN_W'(1)) && (cobra_dir == (r_dir ^ 2'b01)))
                     ? r_dir : cobra_dir;

    assign w_tail_ptr   = r_head - c_PTR_W'(r_len - c_LEN_W'(1));
    assign w_hx         = r_body_x[r_head];
    assign w_hy         = r_body_y[r_head];
    assign w_tx         = r_body_x[w_tail_ptr];
    assign w_ty         = r_body_y[w_tail_ptr];
    assign w_clear_last = (r_cx == c_X_MAX) && (r_cy == c_Y_MAX);
    assign w_tick_done  = (r_tick_cnt == r_period - 32'd1);
    assign w_start_ok   = ((r_state == S_WAIT_START) || (r_state == S_OVER)) && start;
    assign w_len_full   = (r_len == c_LEN_MAX);

    // Growth is resolved inside the same CHECK cycle, so a body hit on the
    // current tail cell can never coincide with pending growth: the tail is
    // about to vacate and the move is legal.
    assign w_hit_tail = (r_nx == w_tx) && (r_ny == w_ty);
    assign w_grow     = (update_rdata == c_FRUIT);
    assign w_accept   = (update_rdata == c_EMPTY) || w_grow ||
                        ((update_rdata == c_BODY) && w_hit_tail);

    // Destination of the head for the direction that will be latched.
    always_comb begin
        w_nx  = w_hx;
        w_ny  = w_hy;
        w_off = 1'b0;
        case (w_dir_eff)
            2'd0: begin
                if (w_hy == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
                    w_ny = c_Y_MAX;
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_ny = w_hy - c_ONE;
                end
            end
            2'd1: begin
                if (w_hy == c_Y_MAX) begin
`ifdef SNAKE_WALL_WRAP_EN
                    w_ny = '0;
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_ny = w_hy + c_ONE;
                end
            end
            2'd2: begin
                if (w_hx == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
                    w_nx = c_X_MAX;
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_nx = w_hx - c_ONE;
                end
            end
            default: begin
                if (w_hx == c_X_MAX) begin
`ifdef SNAKE_WALL_WRAP_EN
                    w_nx = '0;
`else
                    w_off = 1'b1;
`endif
                end else begin
                    w_nx = w_hx + c_ONE;
                end
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT_START, S_OVER: if (start) w_next_state = S_CLEAR;
            S_CLEAR:     if (w_clear_last) w_next_state = S_FRUIT_REQ;
            S_FRUIT_REQ: if (fruta_valid) w_next_state = S_FRUIT_WR;
            S_FRUIT_WR:  w_next_state = S_TICK;
            S_TICK:      if (w_tick_done) w_next_state = S_MOVE;
            S_MOVE:      w_next_state = w_off ? S_OVER : S_CHECK;
            S_CHECK: begin
                if (!w_accept)                w_next_state = S_OVER;
                else if (w_grow && !w_len_full) w_next_state = S_FRUIT_REQ;
                else                          w_next_state = S_ERASE;
            end
            S_ERASE:     w_next_state = r_after_fruit ? S_FRUIT_REQ : S_TICK;
            default:     w_next_state = S_WAIT_START;
        endcase
    end

    // Map and fruit handshake outputs; decoded from state so an async reset
    // drops any write in flight immediately.
    always_comb begin
        update_renable = 1'b0;
        update_rx      = '0;
        update_ry      = '0;
        update_wenable = 1'b0;
        update_wx      = '0;
        update_wy      = '0;
        update_wdata   = c_EMPTY;
        fruta_req      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                update_wenable = 1'b1;
                update_wx      = r_cx;
                update_wy      = r_cy;
                update_wdata   = ((r_cx == c_START_X) && (r_cy == c_START_Y)) ? c_BODY : c_EMPTY;
            end
            S_FRUIT_REQ: fruta_req = 1'b1;
            S_FRUIT_WR: begin
                update_wenable = 1'b1;
                update_wx      = r_fx;
                update_wy      = r_fy;
                update_wdata   = c_FRUIT;
            end
            S_MOVE: begin
                if (!w_off) begin
                    update_renable = 1'b1;
                    update_rx      = w_nx;
                    update_ry      = w_ny;
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    update_wenable = 1'b1;
                    update_wx      = r_nx;
                    update_wy      = r_ny;
                    update_wdata   = c_BODY;
                end
            end
            S_ERASE: begin
                update_wenable = r_erase_en;
                update_wx      = r_ex;
                update_wy      = r_ey;
            end
            default: ;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_WAIT_START;
            r_cx          <= '0;
            r_cy          <= '0;
            r_nx          <= '0;
            r_ny          <= '0;
            r_fx          <= '0;
            r_fy          <= '0;
            r_ex          <= '0;
            r_ey          <= '0;
            r_tick_cnt    <= '0;
            r_period      <= c_T_INIT;
            r_dir         <= 2'd3;
            r_head        <= '0;
            r_len         <= c_LEN_W'(1);
            r_score       <= '0;
            r_game_over   <= 1'b0;
            r_erase_en    <= 1'b0;
            r_after_fruit <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Counter restarts on every entry to TICK.
            r_tick_cnt <= (r_state == S_TICK) ? r_tick_cnt + 32'd1 : '0;
            case (r_state)
                S_WAIT_START, S_OVER: begin
                    if (start) begin
                        r_cx        <= '0;
                        r_cy        <= '0;
                        r_period    <= c_T_INIT;
                        r_dir       <= 2'd3;
                        r_head      <= '0;
                        r_len       <= c_LEN_W'(1);
                        r_score     <= '0;
                        r_game_over <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_cx == c_X_MAX) begin
                        r_cx <= '0;
                        r_cy <= r_cy + c_ONE;
                    end else begin
                        r_cx <= r_cx + c_ONE;
                    end
                end
                S_FRUIT_REQ: begin
                    if (fruta_valid) begin
                        r_fx <= fruta_wx;
                        r_fy <= fruta_wy;
                    end
                end
                S_MOVE: begin
                    r_dir <= w_dir_eff;
                    r_nx  <= w_nx;
                    r_ny  <= w_ny;
                    if (w_off) r_game_over <= 1'b1;
                end
                S_CHECK: begin
                    if (!w_accept) begin
                        r_game_over <= 1'b1;
                    end else begin
                        r_head        <= r_head + c_PTR_W'(1);
                        r_ex          <= w_tx;
                        r_ey          <= w_ty;
                        r_erase_en    <= !w_hit_tail;
                        r_after_fruit <= w_grow;
                        if (w_grow) begin
                            r_score <= r_score + SCORE_W'(1);
                            r_period <= (r_period >= c_T_MIN + c_T_STEP)
                                      ? r_period - c_T_STEP : c_T_MIN;
                            // At full length the tail is erased instead.
                            if (!w_len_full) r_len <= r_len + c_LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Body coordinate buffer; entries past the live length are don't-care.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_body_x[0] <= c_START_X;
            r_body_y[0] <= c_START_Y;
        end else if ((r_state == S_CHECK) && w_accept) begin
            r_body_x[r_head + c_PTR_W'(1)] <= r_nx;
            r_body_y[r_head + c_PTR_W'(1)] <= r_ny;
        end
    end

    assign score     = r_score;
    assign length    = r_len;
    assign game_over = r_game_over;
    assign busy      = (r_state != S_WAIT_START) && (r_state != S_OVER);

endmodule
`default_nettype wire
